// File: rtl/reg_bank_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_reader_pkg
//  Description : Shared constants and state encoding for the register-bank
//                reader. The default widths match the register bank and the
//                processor top.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_reader_pkg;

    localparam int NUM_REGS_DEFAULT = 16;
    localparam int ADDR_W_DEFAULT   = 5;
    localparam int DATA_W_DEFAULT   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_SHOW = 2'd3
    } rbr_state_e;

endpackage
`default_nettype wire

// File: rtl/reg_bank_reader_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_timer
//  Description : Free-running dwell counter with synchronous clear. It raises
//                a terminal-count pulse on the enabled cycle in which the
//                count sits at DWELL-1, then wraps to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer #(
    parameter int DWELL = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int               CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);
    // A clear in the same cycle suppresses the terminal count.
    assign tc_o    = en_i && !clr_i && at_last;

    // Next count: clear wins, otherwise count and wrap at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_bank_reader.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_reader
//  Description : Walks the register bank through read port A, captures each
//                value for the display path and accumulates a modular
//                checksum over every full pass of the address space.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_reader
    import reg_bank_reader_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int DWELL    = 50_000_000,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              auto_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] first_addr_i,
    output logic              rd_req_o,
    input  logic              grant_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [ADDR_W-1:0] disp_addr_o,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              disp_valid_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] sum_o,
    output logic              sum_valid_o
);

    localparam int                LAT_W        = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
    localparam logic [LAT_W-1:0]  LAT_INIT     = LAT_W'(READ_LAT);
    // One extra bit so a bank that fills the whole address space still compares correctly.
    localparam logic [ADDR_W:0]   NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(NUM_REGS - 1);

    rbr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              sum_valid_q, sum_valid_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic              rd_req_q, busy_q;
    logic              auto_prev_q;

    logic [ADDR_W-1:0] first_addr_clamped;
    logic [ADDR_W-1:0] next_addr;
    logic              dwell_clr, dwell_en, dwell_tc;
    logic              advance;

    assign first_addr_clamped = ({1'b0, first_addr_i} >= NUM_REGS_EXT) ? '0 : first_addr_i;
    assign next_addr          = (cur_q == LAST_ADDR) ? '0 : cur_q + 1'b1;

    // The dwell count only runs in SHOW under auto mode; flipping auto restarts it.
    assign dwell_clr = (state_q != ST_SHOW) || (auto_i != auto_prev_q);
    assign dwell_en  = (state_q == ST_SHOW) && auto_i;
    assign advance   = auto_i ? dwell_tc : step_i;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (dwell_clr),
        .en_i  (dwell_en),
        .tc_o  (dwell_tc)
    );

    // Scan sequencing, capture and checksum bookkeeping.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        base_d       = base_q;
        lat_d        = lat_q;
        sum_d        = sum_q;
        sum_valid_d  = 1'b0;
        disp_addr_d  = disp_addr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;

        // The completed total is visible during the sum_valid pulse and is
        // zeroed on the edge that ends it, before the next capture can land.
        if (sum_valid_q) begin
            sum_d = '0;
        end

        if (stop_i) begin
            state_d = ST_IDLE;
        end else if (start_i) begin
            cur_d   = first_addr_clamped;
            base_d  = first_addr_clamped;
            sum_d   = '0;
            state_d = ST_REQ;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_REQ: begin
                    if (grant_i) begin
                        lat_d   = LAT_INIT;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!grant_i) begin
                        state_d = ST_REQ;
                    end else if (lat_q == '0) begin
                        disp_addr_d  = cur_q;
                        disp_data_d  = rd_data_i;
                        disp_valid_d = 1'b1;
                        sum_d        = sum_q + rd_data_i;
                        state_d      = ST_SHOW;
                    end else begin
                        lat_d = lat_q - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (advance) begin
                        cur_d   = next_addr;
                        state_d = ST_REQ;
                        if (next_addr == base_q) begin
                            sum_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            base_q       <= '0;
            lat_q        <= '0;
            sum_q        <= '0;
            sum_valid_q  <= 1'b0;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            rd_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            auto_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            base_q       <= base_d;
            lat_q        <= lat_d;
            sum_q        <= sum_d;
            sum_valid_q  <= sum_valid_d;
            disp_addr_q  <= disp_addr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            rd_req_q     <= (state_d == ST_REQ) || (state_d == ST_WAIT);
            busy_q       <= (state_d != ST_IDLE);
            auto_prev_q  <= auto_i;
        end
    end

    assign rd_req_o     = rd_req_q;
    assign rd_addr_o    = cur_q;
    assign disp_addr_o  = disp_addr_q;
    assign disp_data_o  = disp_data_q;
    assign disp_valid_o = disp_valid_q;
    assign busy_o       = busy_q;
    assign sum_o        = sum_q;
    assign sum_valid_o  = sum_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bank_reader
//  Description : Self-checking bench for reg_bank_reader with a small bank
//                model and an address/checksum reference computed per pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_reader;

    localparam int NR    = 16;
    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int DWELL = 4;
    localparam int RL    = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, auto_m, step;
    logic [AW-1:0] first_addr;
    logic          rd_req, grant;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid, busy, sum_valid;
    logic [DW-1:0] sum;

    logic          grant_dir, grant_rnd, rand_en;
    logic [DW-1:0] bank [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign grant = rand_en ? grant_rnd : grant_dir;

    always @(negedge clk) grant_rnd = ($urandom_range(0, 3) != 0);

    // Bank port A model: one cycle of read latency.
    always @(posedge clk) rd_data <= bank[rd_addr];

    reg_bank_reader #(
        .NUM_REGS (NR),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DWELL    (DWELL),
        .READ_LAT (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .stop_i       (stop),
        .auto_i       (auto_m),
        .step_i       (step),
        .first_addr_i (first_addr),
        .rd_req_o     (rd_req),
        .grant_i      (grant),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .disp_addr_o  (disp_addr),
        .disp_data_o  (disp_data),
        .disp_valid_o (disp_valid),
        .busy_o       (busy),
        .sum_o        (sum),
        .sum_valid_o  (sum_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int fa);
        first_addr = AW'(fa);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_req"},     rd_req,     0);
        chk({tag, "_rd_addr"},    rd_addr,    0);
        chk({tag, "_disp_addr"},  disp_addr,  0);
        chk({tag, "_disp_data"},  disp_data,  0);
        chk({tag, "_disp_valid"}, disp_valid, 0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_sum"},        sum,        0);
        chk({tag, "_sum_valid"},  sum_valid,  0);
    endtask

    // Waits for a capture: the read request falls while the scan is still running.
    task automatic wait_cap(input string tag);
        logic prev;
        bit   done;
        done = 1'b0;
        prev = rd_req;
        for (int n = 0; n < 300 && !done; n++) begin
            tick();
            if (prev && !rd_req && busy) done = 1'b1;
            prev = rd_req;
        end
        chk({tag, "_cap_timeout"}, done, 1);
    endtask

    function automatic int nxt(input int a);
        return (a + 1) % NR;
    endfunction

    // Manual-mode scan against the reference: expected address order and
    // per-pass modular sums come straight from the bank contents.
    task automatic manual_run(input string tag, input int first, input int nsteps,
                              output logic [DW-1:0] pass_sum_obs);
        int            a, base;
        logic [DW-1:0] run;
        pass_sum_obs = '0;
        pulse_start(first);
        a    = (first >= NR) ? 0 : first;
        base = a;
        run  = '0;
        wait_cap(tag);
        run = run + bank[a];
        chk({tag, "_addr"}, disp_addr, a);
        chk({tag, "_data"}, disp_data, bank[a]);
        chk({tag, "_sum"},  sum,       run);
        for (int s = 1; s <= nsteps; s++) begin
            pulse_step();
            if (nxt(a) == base) begin
                chk({tag, "_sv_pass"},  sum_valid, 1);
                chk({tag, "_sum_pass"}, sum,       run);
                pass_sum_obs = sum;
                run = '0;
            end else begin
                chk({tag, "_sv_none"}, sum_valid, 0);
            end
            a = nxt(a);
            wait_cap(tag);
            run = run + bank[a];
            chk({tag, "_addr"}, disp_addr, a);
            chk({tag, "_data"}, disp_data, bank[a]);
            chk({tag, "_sum"},  sum,       run);
        end
    endtask

    initial begin : main
        logic [DW-1:0] ps;
        logic [DW-1:0] run;
        int            a, n, first;
        bit            stable;

        rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; auto_m = 1'b0;
        first_addr = '0; grant_dir = 1'b1; rand_en = 1'b0;
        for (int i = 0; i < 32; i++) bank[i] = DW'(16'h0100 + i);

        // Reset values.
        do_reset();
        chk_reset("rst");

        // Start-to-capture latency with grant held high.
        pulse_start(0);
        chk("lat_c1_rd_req", rd_req, 1);
        chk("lat_c1_busy",   busy,   1);
        chk("lat_c1_addr",   rd_addr, 0);
        tick();
        chk("lat_c2_valid", disp_valid, 0);
        tick();
        chk("lat_c3_valid", disp_valid, 0);
        tick();
        chk("lat_c4_valid", disp_valid, 1);
        chk("lat_c4_data",  disp_data,  16'h0100);
        chk("lat_c4_sum",   sum,        16'h0100);

        // Manual pass over R0..R15 = 0100+i.
        manual_run("man", 0, 16, ps);
        chk("man_sum_1078", ps, 16'h1078);

        // Auto mode from address 14 with a short dwell.
        do_reset();
        auto_m = 1'b1;
        pulse_start(14);
        a   = 14;
        run = '0;
        wait_cap("auto");
        for (int i = 0; i <= 16; i++) begin
            run = run + bank[a];
            chk("auto_addr", disp_addr, a);
            chk("auto_data", disp_data, bank[a]);
            chk("auto_sum",  sum,       run);
            if (i == 16) break;
            n = 0;
            while (!rd_req && n < 50) begin
                tick();
                n++;
            end
            chk("auto_dwell", n, DWELL);
            if (nxt(a) == 14) begin
                chk("auto_sv_pass",  sum_valid, 1);
                chk("auto_sum_pass", sum,       run);
                run = '0;
            end else begin
                chk("auto_sv_none", sum_valid, 0);
            end
            a = nxt(a);
            wait_cap("auto");
        end

        // Toggling auto mid-dwell restarts the dwell count.
        tick();
        tick();
        auto_m = 1'b0;
        tick();
        auto_m = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("auto_toggle_hold", rd_req, 0);
        tick();
        chk("auto_toggle_adv", rd_req, 1);
        auto_m = 1'b0;

        // Grant withheld in REQ, then dropped for one cycle in WAIT.
        do_reset();
        grant_dir = 1'b0;
        stable    = 1'b1;
        pulse_start(5);
        for (int k = 0; k < 10; k++) begin
            if (rd_req !== 1'b1 || rd_addr !== 5'd5) stable = 1'b0;
            tick();
        end
        chk("gnt_withheld_valid", disp_valid, 0);
        grant_dir = 1'b1;
        if (rd_req !== 1'b1 || rd_addr !== 5'd5) stable = 1'b0;
        tick();
        grant_dir = 1'b0;
        if (rd_req !== 1'b1 || rd_addr !== 5'd5) stable = 1'b0;
        tick();
        grant_dir = 1'b1;
        if (rd_req !== 1'b1 || rd_addr !== 5'd5) stable = 1'b0;
        tick();
        if (rd_req !== 1'b1 || rd_addr !== 5'd5) stable = 1'b0;
        tick();
        if (rd_req !== 1'b1 || rd_addr !== 5'd5) stable = 1'b0;
        chk("gnt_early_valid", disp_valid, 0);
        tick();
        chk("gnt_cap_valid", disp_valid, 1);
        chk("gnt_cap_addr",  disp_addr,  5);
        chk("gnt_cap_data",  disp_data,  bank[5]);
        chk("gnt_addr_stable", stable, 1);

        // Checksum overflow with every register at FFFF.
        do_reset();
        for (int i = 0; i < 32; i++) bank[i] = 16'hFFFF;
        manual_run("ovf", 3, 16, ps);
        chk("ovf_sum_fff0", ps, 16'hFFF0);

        // Stop during WAIT keeps the display contents.
        pulse_step();
        tick();
        chk("stop_pre_rd_req", rd_req, 1);
        pulse_stop();
        chk("stop_rd_req",     rd_req,     0);
        chk("stop_busy",       busy,       0);
        chk("stop_disp_addr",  disp_addr,  3);
        chk("stop_disp_data",  disp_data,  16'hFFFF);
        chk("stop_disp_valid", disp_valid, 1);
        pulse_step();
        chk("idle_step_busy", busy, 0);

        // Start during SHOW restarts at the new address with sum cleared.
        for (int i = 0; i < 32; i++) bank[i] = DW'(16'h0100 + i);
        pulse_start(2);
        wait_cap("rs1");
        chk("rs1_addr", disp_addr, 2);
        pulse_start(9);
        chk("rs_rd_req", rd_req,  1);
        chk("rs_rd_addr", rd_addr, 9);
        chk("rs_sum_clr", sum,     0);
        wait_cap("rs2");
        chk("rs2_addr", disp_addr, 9);
        chk("rs2_data", disp_data, 16'h0109);
        chk("rs2_sum",  sum,       16'h0109);

        // Reset while showing a valid capture.
        rst = 1'b1;
        tick();
        chk_reset("midrst");
        rst = 1'b0;

        // Out-of-range start address clamps to 0.
        pulse_start(20);
        chk("clamp_rd_addr", rd_addr, 0);
        wait_cap("clamp");
        chk("clamp_disp_addr", disp_addr, 0);
        chk("clamp_disp_data", disp_data, bank[0]);

        // Random bank contents, random start and random grant.
        do_reset();
        for (int i = 0; i < 32; i++) bank[i] = DW'($urandom);
        rand_en = 1'b1;
        first   = int'($urandom_range(0, 31));
        manual_run("rnd", first, 20, ps);
        rand_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_bank_reader.md
# reg_bank_reader

Read-side companion to the switch-driven instruction entry path. It walks the 16-bit register bank's address space and captures each register's value through a requested read port. It presents the captured address and value to the seven-segment display path, and accumulates a 16-bit modular checksum over a full pass. It sits between the processor top and the register bank read port A, and only drives that port while the top grants it.

## Interface
- NUM_REGS, 16: number of registers scanned; addresses 0..NUM_REGS-1
- ADDR_W, 5: register address width, matching the bank address ports
- DATA_W, 16: register data width
- DWELL, 50_000_000: cycles each value is held in auto mode (1 s at 50 MHz)
- READ_LAT, 1: cycles from `rd_addr` valid (with `grant` high) to `rd_data` valid
- clk  in  1  system clock (CLOCK_50 at top level)
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin scan at `first_addr`
- stop  in  1  one-cycle pulse: abort scan, return to idle
- auto  in  1  1 = advance on dwell timer; 0 = advance on `step`
- step  in  1  one-cycle pulse: advance one register (manual mode only)
- first_addr  in  ADDR_W  scan start address, sampled on `start`
- rd_req  out  1  requests bank read port A
- grant  in  1  top-level grant; the port is owned only while `rd_req && grant`
- rd_addr  out  ADDR_W  address driven to bank port A
- rd_data  in  DATA_W  bank port A output
- disp_addr  out  ADDR_W  address of the displayed value
- disp_data  out  DATA_W  captured register value
- disp_valid  out  1  `disp_data` holds a completed capture
- busy  out  1  FSM not in IDLE
- sum  out  DATA_W  running checksum of captured values
- sum_valid  out  1  one-cycle pulse when a full pass wraps back to `first_addr`

## Operation
- States: IDLE, REQ, WAIT, SHOW.
- IDLE: `rd_req`=0. `start` latches `first_addr` into `cur` and `base`, clears `sum`, then goes to REQ. Other inputs are ignored.
- REQ: `rd_req`=1 and `rd_addr`=`cur`. On `grant`=1, load the latency counter with READ_LAT and go to WAIT. Without grant, remain in REQ indefinitely.
- WAIT: `rd_req` and `rd_addr` are held. If `grant` drops, return to REQ and restart the latency count. When the count expires, capture `rd_data` into `disp_data`, set `disp_addr`=`cur` and `disp_valid`=1, and update `sum` = `sum` + `rd_data` mod 2^DATA_W. Then go to SHOW.
- SHOW: `rd_req`=0. The advance event is the dwell counter reaching DWELL-1 when `auto`=1, or `step` when `auto`=0. On advance, `cur` = `cur`+1, wrapping NUM_REGS-1 to 0, then go to REQ.
- Pass completion: when an advance makes `cur` equal `base`, pulse `sum_valid`, clear `sum` in the same cycle, and continue scanning. Scanning is continuous until `stop`.
- `stop` in any state goes to IDLE next cycle and drops `rd_req`. `disp_*` keep their last values.
- `start` while busy restarts: it acts as `stop` followed by `start` in one cycle.
- `first_addr` ≥ NUM_REGS is clamped to 0.
- `auto` changing in SHOW clears the dwell counter.
- `step` is ignored outside SHOW and when `auto`=1.

## Timing
- Reset: state=IDLE; `rd_req`=0, `rd_addr`=0, `disp_addr`=0, `disp_data`=0, `disp_valid`=0, `busy`=0, `sum`=0, `sum_valid`=0; all counters 0.
- All outputs are registered.
- Sequence with grant held high: `start` at cycle 0; `rd_req` high at cycle 1; capture at cycle 1+1+READ_LAT; `disp_valid` high the following cycle.
- Reset asserted mid-scan overrides every other input and returns to the reset values next cycle.
- `stop` has priority over `start`, which has priority over `step` and the dwell advance.

## Structure
- Shared package holds:
  - state encoding constants (IDLE=0, REQ=1, WAIT=2, SHOW=3);
  - default NUM_REGS, ADDR_W and DATA_W, shared with the register bank and processor top.
- One natural sub-module: `dwell_timer` (load, clear, terminal-count pulse), parameterised by DWELL. Test benches override DWELL to a small value.

## Test plan
- Manual mode, DWELL irrelevant, grant=1, bank R0..R15 = 16'h0100+i. `start` with `first_addr`=0, then 15 `step` pulses → `disp_data` sequence 0100..010F. Sixteenth `step` → `sum_valid` pulse with `sum`=16'h1078.
- Auto mode, DWELL=4, `first_addr`=14 → addresses 14, 15, 0, 1…, each shown for 4 cycles. The wrap 15→0 raises no `sum_valid`; returning to 14 does.
- Grant withheld for 10 cycles in REQ, then grant dropped for one cycle in WAIT → no capture until a full READ_LAT cycles with grant high; `rd_addr` is stable throughout.
- Checksum overflow: all registers = 16'hFFFF → after a full pass `sum`=16'hFFF0.
- `stop` during WAIT → IDLE next cycle, `rd_req`=0, `disp_*` unchanged. `start` during SHOW → restart at the new `first_addr` with `sum` cleared.
- Reset asserted in SHOW with `disp_valid`=1 → all outputs return to reset values next cycle. `first_addr`=20 → scan begins at 0.
